// File: rtl/clb_cfg_loader_if.sv
// clb_cfg_loader_if: serial load stream and committed-configuration bus of the clb49 loader
interface clb_cfg_loader_if;
  logic        PROG;
  logic        DIN;
  logic        DVALID;
  logic        DREADY;
  logic [36:0] CFG;
  logic        CFG_VALID;
  logic        HOLD;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  modport master (output PROG, DIN, DVALID, input DREADY, CFG, CFG_VALID, HOLD, BUSY, DONE, ERR);
  modport slave  (input PROG, DIN, DVALID, output DREADY, CFG, CFG_VALID, HOLD, BUSY, DONE, ERR);
endinterface

// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: sync-hunting serial loader committing 37-bit clb49 frames; CLB_CFG_PARITY_EN adds an even-parity bit
module clb_cfg_loader #(
  parameter logic [7:0] SYNC_WORD = 8'hA5,
  parameter int         TIMEOUT   = 255
) (
  input logic             K,
  input logic             RST,
  clb_cfg_loader_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LOAD, S_ERROR, S_DONE} state_t;
  // power-up config: mem 0116, mux2/3/4 = 2'b10, o2m*_1 = 1
  localparam logic [36:0] CFG_RST = 37'h0_380A_80116;
`ifdef CLB_CFG_PARITY_EN
  localparam logic [5:0] LAST = 6'd37;
`else
  localparam logic [5:0] LAST = 6'd36;
`endif
  state_t      r_state;
  logic [7:0]  r_win;
  logic [7:0]  r_idle;
  logic [5:0]  r_cnt;
  logic [36:0] r_shd;
  logic [36:0] r_cfg;
  logic        r_act;
  logic        r_vld;
  logic        r_done;
  logic        r_err;
  logic        w_acc;
  logic [7:0]  w_win;
  logic [36:0] w_shd;
  // r_act is high exactly in SYNC and LOAD, so it doubles as DREADY, BUSY and HOLD
  assign w_acc = bus.DVALID && r_act;
  assign w_win = {r_win[6:0], bus.DIN};
  assign w_shd = {r_shd[35:0], bus.DIN};
  assign bus.DREADY    = r_act;
  assign bus.BUSY      = r_act;
  assign bus.HOLD      = r_act;
  assign bus.CFG       = r_cfg;
  assign bus.CFG_VALID = r_vld;
  assign bus.DONE      = r_done;
  assign bus.ERR       = r_err;
  // sequencer: sync hunt, frame shift, commit or error; PROG restarts from any state
  always_ff @(posedge K) begin
    r_vld <= 1'b0;
    if (RST) begin
      r_state <= S_IDLE;
      r_win   <= '0;
      r_idle  <= '0;
      r_cnt   <= '0;
      r_shd   <= '0;
      r_cfg   <= CFG_RST;
      r_act   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (bus.PROG) begin
      r_state <= S_SYNC;
      r_win   <= '0;
      r_idle  <= '0;
      r_cnt   <= '0;
      r_act   <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_SYNC: if (w_acc) begin
          r_win <= w_win;
          if (w_win == SYNC_WORD) r_state <= S_LOAD;
        end
        S_LOAD: if (w_acc) begin
          r_shd  <= w_shd;
          r_cnt  <= r_cnt + 6'd1;
          r_idle <= '0;
          if (r_cnt == LAST) begin
            r_act <= 1'b0;
`ifdef CLB_CFG_PARITY_EN
            if (^{r_shd, bus.DIN}) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_cfg   <= r_shd;
              r_vld   <= 1'b1;
            end
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_cfg   <= w_shd;
            r_vld   <= 1'b1;
`endif
          end
        end else if (r_idle == 8'(TIMEOUT - 1)) begin
          r_state <= S_ERROR;
          r_err   <= 1'b1;
          r_act   <= 1'b0;
        end else begin
          r_idle <= r_idle + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_clb_cfg_loader.sv
// tb_clb_cfg_loader: randomized frame-level checks of clb_cfg_loader against expected-configuration model
module tb_clb_cfg_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n_vld = 0;
  logic [36:0] exp_cfg;
  clb_cfg_loader_if bus();
  clb_cfg_loader dut (.K(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;

  // power-up configuration built from its fields, MSB field first
  function automatic logic [36:0] reset_cfg();
    return {1'b0, 2'b00, 3'b111, 3'b000, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 16'h0116};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    n_vld += int'(bus.CFG_VALID);
  endtask

  task automatic send(input logic [63:0] v, input int n, input int maxgap);
    for (int i = n - 1; i >= 0; i--) begin
      for (int g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0; g > 0; g--) tick();
      bus.DVALID = 1'b1;
      bus.DIN = v[i];
      tick();
      bus.DVALID = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [36:0] d, input int maxgap);
    send({27'b0, d}, 37, maxgap);
`ifdef CLB_CFG_PARITY_EN
    send({63'b0, ^d}, 1, maxgap);
`endif
  endtask

  task automatic prog();
    bus.PROG = 1'b1;
    tick();
    bus.PROG = 1'b0;
    n_vld = 0;
  endtask

  task automatic check_frame(input string nm, input logic [36:0] d);
    total++; if (bus.CFG !== d) begin bad++; $display("FAIL %s cfg got=%h exp=%h", nm, bus.CFG, d); end
    total++; if (n_vld !== 1) begin bad++; $display("FAIL %s vld_count got=%0d exp=1", nm, n_vld); end
    total++; if ({bus.DONE, bus.ERR, bus.HOLD, bus.BUSY, bus.DREADY} !== 5'b10000) begin bad++; $display("FAIL %s status got=%b exp=10000", nm, {bus.DONE, bus.ERR, bus.HOLD, bus.BUSY, bus.DREADY}); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++; if (bus.CFG !== reset_cfg()) begin bad++; $display("FAIL reset_cfg got=%h exp=%h", bus.CFG, reset_cfg()); end
    total++; if ({bus.DREADY, bus.HOLD, bus.BUSY, bus.DONE, bus.ERR, bus.CFG_VALID} !== 6'b0) begin bad++; $display("FAIL reset_status got=%b exp=000000", {bus.DREADY, bus.HOLD, bus.BUSY, bus.DONE, bus.ERR, bus.CFG_VALID}); end
    exp_cfg = reset_cfg();
  endtask

  task automatic test_clean_frame();
    prog();
    total++; if ({bus.DREADY, bus.BUSY, bus.HOLD} !== 3'b111) begin bad++; $display("FAIL prog_entry got=%b exp=111", {bus.DREADY, bus.BUSY, bus.HOLD}); end
    send(64'hA5, 8, 0);
    exp_cfg = 37'h0_0000_0FFFF;
    send_frame(exp_cfg, 0);
    check_frame("clean", exp_cfg);
    for (int i = 0; i < 3; i++) tick();
    total++; if (n_vld !== 1 || bus.CFG_VALID !== 1'b0) begin bad++; $display("FAIL clean_single_pulse got=%0d exp=1", n_vld); end
  endtask

  task automatic test_noise_gaps();
    logic [36:0] d;
    d = 37'({$urandom(), $urandom()});
    prog();
    send(64'b1011010, 7, 0);
    total++; if (bus.DREADY !== 1'b1) begin bad++; $display("FAIL noise_still_sync got=%b exp=1", bus.DREADY); end
    send(64'hA5, 8, 0);
    send_frame(d, 20);
    exp_cfg = d;
    check_frame("noise_gaps", d);
  endtask

  task automatic test_timeout();
    prog();
    send(64'hA5, 8, 0);
    send(64'($urandom()), 10, 0);
    for (int i = 0; i < 254; i++) tick();
    total++; if (bus.ERR !== 1'b0 || bus.HOLD !== 1'b1) begin bad++; $display("FAIL timeout_early err=%b hold=%b exp err=0 hold=1", bus.ERR, bus.HOLD); end
    tick();
    total++; if (bus.ERR !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b exp=1", bus.ERR); end
    total++; if (bus.CFG !== exp_cfg) begin bad++; $display("FAIL timeout_cfg got=%h exp=%h", bus.CFG, exp_cfg); end
    total++; if (n_vld !== 0 || {bus.HOLD, bus.BUSY, bus.DONE} !== 3'b000) begin bad++; $display("FAIL timeout_status vld=%0d hbd=%b exp 0 000", n_vld, {bus.HOLD, bus.BUSY, bus.DONE}); end
  endtask

  task automatic test_prog_restart();
    logic [36:0] d;
    d = 37'({$urandom(), $urandom()});
    prog();
    total++; if (bus.ERR !== 1'b0) begin bad++; $display("FAIL prog_clears_err got=%b exp=0", bus.ERR); end
    send(64'hA5, 8, 0);
    send(64'({$urandom(), $urandom()}), 20, 0);
    bus.DVALID = 1'b1;
    bus.DIN = 1'b1;
    prog();
    bus.DVALID = 1'b0;
    send(64'hA5, 8, 0);
    send_frame(d, 3);
    exp_cfg = d;
    check_frame("prog_restart", d);
  endtask

  task automatic test_rst_midframe();
    prog();
    send(64'hA5, 8, 0);
    send(64'({$urandom(), $urandom()}), 20, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.CFG !== reset_cfg()) begin bad++; $display("FAIL rst_mid_cfg got=%h exp=%h", bus.CFG, reset_cfg()); end
    total++; if ({bus.DREADY, bus.HOLD, bus.BUSY, bus.DONE, bus.ERR, bus.CFG_VALID} !== 6'b0) begin bad++; $display("FAIL rst_mid_status got=%b exp=000000", {bus.DREADY, bus.HOLD, bus.BUSY, bus.DONE, bus.ERR, bus.CFG_VALID}); end
    exp_cfg = reset_cfg();
  endtask

`ifdef CLB_CFG_PARITY_EN
  task automatic test_parity_error();
    logic [36:0] d;
    d = 37'({$urandom(), $urandom()});
    prog();
    send(64'hA5, 8, 0);
    send({27'b0, d}, 37, 2);
    send({63'b0, ~(^d)}, 1, 0);
    total++; if (bus.ERR !== 1'b1 || bus.DONE !== 1'b0) begin bad++; $display("FAIL parity_err err=%b done=%b exp 1 0", bus.ERR, bus.DONE); end
    total++; if (n_vld !== 0 || bus.CFG !== exp_cfg) begin bad++; $display("FAIL parity_cfg vld=%0d cfg=%h exp 0 %h", n_vld, bus.CFG, exp_cfg); end
    prog();
    total++; if (bus.ERR !== 1'b0 || bus.DREADY !== 1'b1) begin bad++; $display("FAIL parity_prog err=%b dready=%b exp 0 1", bus.ERR, bus.DREADY); end
    send(64'hA5, 8, 0);
    send_frame(d, 0);
    exp_cfg = d;
    check_frame("parity_recover", d);
  endtask
`endif

  task automatic test_back_to_back();
    logic [36:0] d;
    for (int k = 0; k < 4; k++) begin
      d = 37'({$urandom(), $urandom()});
      prog();
      send(64'hA5, 8, k);
      send_frame(d, k * 5);
      exp_cfg = d;
      check_frame("back_to_back", d);
    end
  endtask

  initial begin
    bus.PROG = 1'b0;
    bus.DIN = 1'b0;
    bus.DVALID = 1'b0;
    test_reset();
    test_clean_frame();
    test_noise_gaps();
    test_timeout();
    test_prog_restart();
    test_rst_midframe();
`ifdef CLB_CFG_PARITY_EN
    test_parity_error();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
